tetris_input_ctrl: RTL

//  Input front end for the tetris core; its outputs drive the core's Start/Left/Right/Down inputs.
//  - Synchronises and debounces raw board buttons.
//  - Turns held buttons into single-cycle move pulses with delayed auto-repeat.
//  - Generates the periodic gravity Down pulse while a game is active.

---
 rtl/tetris_input_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: debounced, auto-repeating button front end plus gravity Down pulses for the tetris core
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous reset, active low
//   i_enable     game active; gates Left/Right/Down and gravity
//   i_btn_l/r/d  raw move buttons, asynchronous, active high
//   i_btn_start  raw start button, asynchronous, active high
//   o_left/o_right/o_down/o_start  registered single-cycle pulses to the core
module tetris_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_RATE     = 8,
    parameter int GRAVITY_PERIOD  = 64,
    parameter int CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_btn_l,
    input  logic i_btn_r,
    input  logic i_btn_d,
    input  logic i_btn_start,
    output logic o_left,
    output logic o_right,
    output logic o_down,
    output logic o_start
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] GP_LAST = CNT_W'(GRAVITY_PERIOD - 1);

    logic [3:0] w_raw;
    logic [3:0] w_db;
    logic [2:0] w_pulse;
    logic w_conflict;
    logic w_grav;
    logic w_down;
    logic [CNT_W-1:0] r_gc;
    logic r_st_d;
    logic r_left;
    logic r_right;
    logic r_down;
    logic r_start;

    // channel order: 0 left, 1 right, 2 down, 3 start
    assign w_raw = {i_btn_start, i_btn_d, i_btn_r, i_btn_l};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        logic r_s1;
        logic r_s2;
        logic r_db;
        logic [CNT_W-1:0] r_cnt;
        // cnt counts consecutive synced samples disagreeing with db; any agreement restarts it
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1  <= w_raw[g];
                r_s2  <= r_s1;
                r_db  <= (r_s2 != r_db && r_cnt == DB_LAST) ? r_s2 : r_db;
                r_cnt <= (r_s2 == r_db || r_cnt == DB_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
        assign w_db[g] = r_db;
    end

    for (genvar g = 0; g < 3; g++) begin : g_rep
        logic [1:0] r_state;
        logic [CNT_W-1:0] r_rc;
        // IDLE with db high can only be the first cycle after the debounced rise
        assign w_pulse[g] = w_db[g] && (r_state == IDLE ||
                                        (r_state == DELAY && r_rc == RD_LAST) ||
                                        (r_state == REPEAT && r_rc == RR_LAST));
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state <= IDLE;
                r_rc    <= '0;
            end else if (!w_db[g]) begin
                r_state <= IDLE;
                r_rc    <= '0;
            end else if (r_state == IDLE) begin
                r_state <= DELAY;
                r_rc    <= '0;
            end else if (r_state == DELAY) begin
                r_state <= (r_rc == RD_LAST) ? REPEAT : DELAY;
                r_rc    <= (r_rc == RD_LAST) ? '0 : r_rc + 1'b1;
            end else if (r_state == REPEAT) begin
                r_rc    <= (r_rc == RR_LAST) ? '0 : r_rc + 1'b1;
            end else begin
                r_state <= IDLE;
                r_rc    <= '0;
            end
        end
    end

    assign w_conflict = w_db[0] & w_db[1];
    assign w_grav     = i_enable && (r_gc == GP_LAST);
    assign w_down     = i_enable && (w_pulse[2] || w_grav);

    // Down has priority: a coinciding Left/Right pulse is dropped so gravity is never lost
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gc    <= '0;
            r_st_d  <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_down  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_gc    <= (!i_enable || w_down) ? '0 : r_gc + 1'b1;
            r_left  <= i_enable && w_pulse[0] && !w_conflict && !w_down;
            r_right <= i_enable && w_pulse[1] && !w_conflict && !w_down;
            r_down  <= w_down;
            r_st_d  <= w_db[3];
            r_start <= w_db[3] && !r_st_d;
        end
    end

    assign o_left  = r_left;
    assign o_right = r_right;
    assign o_down  = r_down;
    assign o_start = r_start;
endmodule
